dma_burst_read_engine: RTL

- AXI4 burst-read engine for the DMA read path; next generation of the single-beat DMA read FSM.
- On start_read, reads r_size_data bytes from raddr_reg using INCR bursts of up to MAX_BURST beats, with parametrised data width.
- Pushes every returned beat into the read FIFO and reports completion and error status to the DMA controller.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_burst_calc.sv | 47 ++++
 rtl/dma_burst_read_engine.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared AXI constants, FSM encoding and beat-size helper for the DMA read path
package dma_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_SPACE,
        ST_ADDR,
        ST_DATA
    } dma_state_e;

    function automatic logic [2:0] beat_bytes_log2(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - combinational burst-length selection; DMA_RD_4K_SPLIT_EN adds the 4 KB clamp
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int SIZE_W    = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [SIZE_W:0]   beats_left_i,
    input  logic [ADDR_W-1:0] cur_addr_i,
    output logic [8:0]        blen_o
);

    logic [8:0] blen_max;

    always_comb begin
        if (beats_left_i > (SIZE_W + 1)'(MAX_BURST)) begin
            blen_max = 9'(MAX_BURST);
        end else begin
            blen_max = 9'(beats_left_i);
        end
    end

`ifdef DMA_RD_4K_SPLIT_EN
    localparam int LOG2B = int'(beat_bytes_log2(DATA_W));

    logic [12:0] room_bytes;
    logic [12:0] room_beats;

    // The address is beat-aligned, so the remaining page room divides exactly into beats.
    always_comb begin
        room_bytes = 13'd4096 - {1'b0, cur_addr_i[11:0]};
        room_beats = room_bytes >> LOG2B;
        if ({4'b0, blen_max} > room_beats) begin
            blen_o = room_beats[8:0];
        end else begin
            blen_o = blen_max;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cur_addr_i, 32'(DATA_W)};
    assign blen_o     = blen_max;
`endif

endmodule

// File: rtl/dma_burst_read_engine.sv
// rtl/dma_burst_read_engine.sv - AXI4 INCR burst-read engine feeding the DMA read FIFO
// Optional 4 KB burst splitting is enabled by defining DMA_RD_4K_SPLIT_EN.
module dma_burst_read_engine
    import dma_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int SIZE_W    = 16,
    parameter int MAX_BURST = 16,
    parameter int FREE_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [SIZE_W-1:0] r_size_data,
    input  logic [ADDR_W-1:0] raddr_reg,
    output logic              read_done,
    output logic              read_err,
    output logic              busy,
    input  logic              fifo_full,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              wen,
    output logic [DATA_W-1:0] data_in,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast
);

    localparam int LOG2B = int'(beat_bytes_log2(DATA_W));
    localparam int BYTES = DATA_W / 8;
    localparam int BL_W  = SIZE_W + 1;

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BL_W-1:0]   beats_left_q, beats_left_d;
    logic [8:0]        blen_q, blen_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              arvalid_q, arvalid_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [8:0]        blen_calc;
    logic [BL_W-1:0]   start_beats;
    logic [BL_W-1:0]   beats_after;
    logic              r_beat;
    logic              last_beat;

    dma_burst_calc #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .SIZE_W    (SIZE_W),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .beats_left_i (beats_left_q),
        .cur_addr_i   (addr_q),
        .blen_o       (blen_calc)
    );

    // One extra bit keeps the round-up of a maximal size from overflowing.
    assign start_beats = ({1'b0, r_size_data} + BL_W'(BYTES - 1)) >> LOG2B;
    assign beats_after = beats_left_q - BL_W'(blen_q);
    assign axi_rready  = (state_q == ST_DATA) && !fifo_full;
    assign r_beat      = axi_rvalid && axi_rready;
    assign last_beat   = (beat_cnt_q == 9'd1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        blen_d       = blen_q;
        beat_cnt_d   = beat_cnt_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        wen_d        = 1'b0;
        data_d       = data_q;
        err_d        = err_q;
        done_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_read) begin
                    addr_d       = raddr_reg;
                    beats_left_d = start_beats;
                    err_d        = 1'b0;
                    // Zero-length transfers finish straight from IDLE without touching AXI.
                    if (start_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                blen_d     = blen_calc;
                beat_cnt_d = blen_calc;
                arlen_d    = 8'(blen_calc - 9'd1);
                state_d    = ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: begin
                if (32'(fifo_free) >= 32'(blen_q)) begin
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_beat) begin
                    wen_d      = 1'b1;
                    data_d     = axi_rdata;
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (axi_rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (axi_rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        addr_d       = addr_q + (ADDR_W'(blen_q) << LOG2B);
                        beats_left_d = beats_after;
                        if (beats_after != '0) begin
                            state_d = ST_CALC;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            blen_q       <= '0;
            beat_cnt_q   <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            wen_q        <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            blen_q       <= blen_d;
            beat_cnt_q   <= beat_cnt_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            wen_q        <= wen_d;
            data_q       <= data_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = beat_bytes_log2(DATA_W);
    assign axi_arburst = BURST_INCR;
    assign wen         = wen_q;
    assign data_in     = data_q;
    assign read_done   = done_q;
    assign read_err    = err_q;
    assign busy        = busy_q;

endmodule
